// File: rtl/regfile_mp_sb.sv
// Multi-port register file with write-back bypass and a busy-bit scoreboard.
// ID reads operands and issues destinations; WB retires results through the write ports.
module regfile_mp_sb #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 32,
  parameter int NRD     = 2,
  parameter int NWR     = 1,
  parameter int ZERO_R0 = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NWR-1:0]       we,
  input  logic [NWR*$clog2(DEPTH)-1:0] waddr,
  input  logic [NWR*WIDTH-1:0] wdata,
  input  logic [NRD-1:0]       re,
  input  logic [NRD*$clog2(DEPTH)-1:0] raddr,
  output logic [NRD*WIDTH-1:0] rdata,
  output logic [NRD-1:0]       rbusy,
  input  logic                 iss_valid,
  input  logic [$clog2(DEPTH)-1:0] iss_addr,
  output logic [DEPTH-1:0]     busy_vec
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] whit;
  logic [DEPTH-1:0] setv;
  logic [WIDTH-1:0] wval [DEPTH];

  // Resolve write ports per register; a later port overwrites an earlier one, so the highest index wins.
  always_comb begin
    for (int a = 0; a < DEPTH; a++) begin
      whit[a] = 1'b0;
      wval[a] = '0;
      setv[a] = 1'b0;
      for (int k = 0; k < NWR; k++) begin
        if (we[k] && (waddr[k*AW +: AW] == AW'(a))) begin
          whit[a] = 1'b1;
          wval[a] = wdata[k*WIDTH +: WIDTH];
        end
      end
      if (iss_valid && (iss_addr == AW'(a))) setv[a] = 1'b1;
      if ((ZERO_R0 != 0) && (a == 0)) begin
        whit[a] = 1'b0;
        setv[a] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int a = 0; a < DEPTH; a++) mem[a] <= '0;
      busy <= '0;
    end else begin
      for (int a = 0; a < DEPTH; a++) begin
        if (whit[a]) mem[a] <= wval[a];
      end
      // A same-cycle issue names a newer producer, so it outranks the retiring write-back.
      busy <= setv | (busy & ~whit);
    end
  end

  always_comb begin
    logic [AW-1:0] ra;
    ra    = '0;
    rdata = '0;
    rbusy = '0;
    for (int j = 0; j < NRD; j++) begin
      ra = raddr[j*AW +: AW];
      if (rst && re[j]) begin
        rbusy[j] = busy[ra] & ~whit[ra];
        if ((ZERO_R0 != 0) && (ra == '0))
          rdata[j*WIDTH +: WIDTH] = '0;
        else if (whit[ra])
          rdata[j*WIDTH +: WIDTH] = wval[ra];
        else
          rdata[j*WIDTH +: WIDTH] = mem[ra];
      end
    end
  end

  assign busy_vec = busy;

endmodule
